// File: rtl/vr_producer.sv
// Valid/ready sequence source: on start, emits len items base, base+step, ...
// with an optional idle gap between items, and keeps transfer/stall statistics.
module vr_producer #(
  parameter int DW = 8,
  parameter int GW = 4,
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          o_prp_valid,
  output logic [DW-1:0] o_prp_data,
  input  logic          i_prp_rdy,
  input  logic          i_start,
  input  logic [DW-1:0] i_base,
  input  logic [DW-1:0] i_step,
  input  logic [7:0]    i_len,
  input  logic [GW-1:0] i_gap,
  output logic          o_busy,
  output logic          o_done,
  output logic [7:0]    o_sent_cnt,
  output logic [SW-1:0] o_stall_cnt
);

  // state | meaning
  // IDLE  | waiting for start; statistics hold
  // SEND  | valid high, item held until the consumer takes it
  // GAP   | valid low, counting down idle cycles before the next item
  // DONE  | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t        r_state;
  logic [DW-1:0] r_step;
  logic [7:0]    r_len;
  logic [GW-1:0] r_gap;
  logic [GW-1:0] r_gap_cnt;
  logic          w_xfer;
  logic          w_last;

  assign w_xfer = o_prp_valid & i_prp_rdy;
  assign w_last = (o_sent_cnt + 8'd1) == r_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_step      <= '0;
      r_len       <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      o_prp_valid <= 1'b0;
      o_prp_data  <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_sent_cnt  <= '0;
      o_stall_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_step      <= i_step;
            r_len       <= i_len;
            r_gap       <= i_gap;
            o_sent_cnt  <= '0;
            o_stall_cnt <= '0;
            o_busy      <= 1'b1;
            o_prp_data  <= i_base;
            if (i_len == 8'd0) begin
              r_state <= DONE;
              o_done  <= 1'b1;
            end else begin
              r_state     <= SEND;
              o_prp_valid <= 1'b1;
            end
          end
        end
        SEND: begin
          if (!i_prp_rdy && (o_stall_cnt != {SW{1'b1}}))
            o_stall_cnt <= o_stall_cnt + 1'b1;
          if (w_xfer) begin
            o_sent_cnt <= o_sent_cnt + 8'd1;
            if (w_last) begin
              r_state     <= DONE;
              o_prp_valid <= 1'b0;
              o_done      <= 1'b1;
            end else begin
              o_prp_data <= o_prp_data + r_step;
              if (r_gap != '0) begin
                r_state     <= GAP;
                r_gap_cnt   <= r_gap;
                o_prp_valid <= 1'b0;
              end
            end
          end
        end
        GAP: begin
          // terminal count at 1 gives exactly r_gap cycles with valid low
          if (r_gap_cnt == {{(GW-1){1'b0}}, 1'b1}) begin
            r_state     <= SEND;
            o_prp_valid <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vr_producer.sv
// Bench for vr_producer: timeline reference model of the item stream,
// directed scenarios plus randomized sequences and ready patterns.
module tb_vr_producer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        o_prp_valid;
  logic [7:0]  o_prp_data;
  logic        i_prp_rdy = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_base = '0;
  logic [7:0]  i_step = '0;
  logic [7:0]  i_len = '0;
  logic [3:0]  i_gap = '0;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_sent_cnt;
  logic [15:0] o_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  vr_producer #(.DW(8), .GW(4), .SW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .o_prp_valid(o_prp_valid), .o_prp_data(o_prp_data), .i_prp_rdy(i_prp_rdy),
    .i_start(i_start), .i_base(i_base), .i_step(i_step), .i_len(i_len), .i_gap(i_gap),
    .o_busy(o_busy), .o_done(o_done), .o_sent_cnt(o_sent_cnt), .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  // mode: 0 random rdy, 1 rdy always high, 2 rdy high every 4th cycle,
  //       3 rdy low 5 cycles then high, with a stray start pulse mid-sequence
  task automatic run_seq(input logic [7:0] b, input logic [7:0] s, input logic [7:0] l,
                         input logic [3:0] g, input int mode,
                         output int done_cyc, output int stalls);
    int k, gap_left, exp_stall, cyc;
    bit exp_valid, rdy, fin;
    logic [7:0] kk, exp_data;
    @(negedge clk);
    i_base = b; i_step = s; i_len = l; i_gap = g; i_start = 1'b1; i_prp_rdy = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    i_base = 8'($urandom); i_step = 8'($urandom); i_len = 8'($urandom); i_gap = 4'($urandom);
    k = 0; gap_left = 0; exp_stall = 0; cyc = 1; fin = (l == 8'd0);
    while (!fin && cyc < 3000) begin
      exp_valid = (gap_left == 0);
      kk = k[7:0];
      exp_data = b + s * kk;
      n_cmp++;
      if (o_prp_valid !== exp_valid || o_busy !== 1'b1 || o_done !== 1'b0) begin
        n_bad++;
        $display("FAIL seq_ctrl cyc=%0d valid/busy/done got %b%b%b want %b10",
                 cyc, o_prp_valid, o_busy, o_done, exp_valid);
      end
      if (exp_valid) begin
        n_cmp++;
        if (o_prp_data !== exp_data) begin
          n_bad++;
          $display("FAIL seq_data item=%0d got %h want %h", k, o_prp_data, exp_data);
        end
      end
      case (mode)
        0:       rdy = 1'($urandom_range(0, 1));
        1:       rdy = 1'b1;
        2:       rdy = (cyc % 4 == 1);
        default: rdy = (cyc > 5);
      endcase
      if (mode == 3 && cyc == 2) begin
        i_start = 1'b1; i_base = 8'hAA; i_step = 8'h33; i_len = 8'd1; i_gap = 4'd7;
      end else begin
        i_start = 1'b0;
      end
      i_prp_rdy = rdy;
      if (exp_valid && !rdy) exp_stall++;
      else if (exp_valid && rdy) begin
        k++;
        if (k == int'(l)) fin = 1'b1;
        else gap_left = int'(g);
      end else gap_left--;
      @(negedge clk);
      cyc++;
    end
    i_start = 1'b0; i_prp_rdy = 1'b0;
    n_cmp++;
    if (!fin) begin
      n_bad++;
      $display("FAIL seq_timeout got %0d items want %0d", k, l);
    end
    done_cyc = cyc;
    stalls = exp_stall;
    n_cmp++;
    if (o_done !== 1'b1 || o_prp_valid !== 1'b0 || o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL done_cycle done/valid/busy got %b%b%b want 101", o_done, o_prp_valid, o_busy);
    end
    n_cmp++;
    if (o_sent_cnt !== l || o_stall_cnt !== exp_stall[15:0]) begin
      n_bad++;
      $display("FAIL stats sent=%0d stall=%0d want sent=%0d stall=%0d",
               o_sent_cnt, o_stall_cnt, l, exp_stall);
    end
    @(negedge clk);
    n_cmp++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_prp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after done/busy/valid got %b%b%b want 000", o_done, o_busy, o_prp_valid);
    end
    n_cmp++;
    if (o_sent_cnt !== l || o_stall_cnt !== exp_stall[15:0]) begin
      n_bad++;
      $display("FAIL stats_hold sent=%0d stall=%0d want sent=%0d stall=%0d",
               o_sent_cnt, o_stall_cnt, l, exp_stall);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({o_prp_valid, o_prp_data, o_busy, o_done, o_sent_cnt, o_stall_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_state valid=%b data=%h busy=%b done=%b sent=%0d stall=%0d want all 0",
               o_prp_valid, o_prp_data, o_busy, o_done, o_sent_cnt, o_stall_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int dc, st;
    run_seq(8'h10, 8'h01, 8'd4, 4'd0, 2, dc, st);
    n_cmp++;
    if (o_stall_cnt !== 16'd9 || dc != 14) begin
      n_bad++;
      $display("FAIL b2b_stall stall=%0d done_cyc=%0d want 9 and 14", o_stall_cnt, dc);
    end
  endtask

  task automatic test_gap();
    int dc, st;
    run_seq(8'h00, 8'h02, 8'd4, 4'd2, 1, dc, st);
    n_cmp++;
    if (dc != 11) begin
      n_bad++;
      $display("FAIL gap_timing done_cyc=%0d want 11", dc);
    end
    run_seq(8'h00, 8'h02, 8'd4, 4'd2, 0, dc, st);
  endtask

  task automatic test_wrap();
    int dc, st;
    run_seq(8'hF0, 8'h10, 8'd3, 4'd0, 1, dc, st);
    n_cmp++;
    if (dc != 4) begin
      n_bad++;
      $display("FAIL wrap_done_cycle got %0d want 4", dc);
    end
  endtask

  task automatic test_stall_hold();
    int dc, st;
    run_seq(8'h3C, 8'h05, 8'd1, 4'd0, 3, dc, st);
    n_cmp++;
    if (o_stall_cnt !== 16'd5 || o_sent_cnt !== 8'd1) begin
      n_bad++;
      $display("FAIL stall_hold stall=%0d sent=%0d want 5 and 1", o_stall_cnt, o_sent_cnt);
    end
  endtask

  task automatic test_zero_len();
    int dc, st;
    run_seq(8'h99, 8'h01, 8'd0, 4'd3, 1, dc, st);
    n_cmp++;
    if (dc != 1 || o_sent_cnt !== 8'd0) begin
      n_bad++;
      $display("FAIL zero_len done_cyc=%0d sent=%0d want 1 and 0", dc, o_sent_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int dc, st;
    @(negedge clk);
    i_base = 8'h77; i_step = 8'h01; i_len = 8'd10; i_gap = 4'd0; i_start = 1'b1; i_prp_rdy = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_prp_valid !== 1'b1 || o_prp_data !== 8'h77) begin
      n_bad++;
      $display("FAIL pre_reset valid=%b data=%h want 1 77", o_prp_valid, o_prp_data);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o_prp_valid, o_prp_data, o_busy, o_done, o_sent_cnt, o_stall_cnt} !== '0) begin
      n_bad++;
      $display("FAIL async_reset valid=%b data=%h busy=%b stall=%0d want all 0",
               o_prp_valid, o_prp_data, o_busy, o_stall_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(8'h55, 8'($urandom), 8'd1, 4'd0, 1, dc, st);
  endtask

  task automatic test_random();
    int dc, st;
    for (int n = 0; n < 8; n++)
      run_seq(8'($urandom), 8'($urandom), 8'($urandom_range(0, 12)),
              4'($urandom_range(0, 3)), 0, dc, st);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_wrap();
    test_stall_hold();
    test_zero_len();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
